bitwise_inverse_seq: RTL and testbench
======================================

// Module: bitwise_inverse_seq
// PURPOSE
//   Receiving-end counterpart of the 4-bit bitwise unit. Given operand a, an observed result r and
//   an opcode, the block recovers operand b: a=a, r=r, op -> b. It also reports which bits of b are
//   uniquely determined and whether r is reachable from a at all.
//   Processes a WIDTH-bit word one 4-bit lane per clock, LSB lane first. Valid/ready handshake on
//   both sides. Sits behind the bitwise result path as a checker/decoder.
// PARAMETERS
//   WIDTH   16   operand width; must be a multiple of 4 (NLANES = WIDTH/4)
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous, active-high reset
//   in_valid    in   1      request valid
//   in_ready    out  1      request accepted on edge where in_valid & in_ready
//   a_in        in   WIDTH  known operand a
//   r_in        in   WIDTH  observed result
//   op_in       in   3      0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 illegal
//   out_valid   out  1      response valid
//   out_ready   in   1      response consumed on edge where out_valid & out_ready
//   b_out       out  WIDTH  recovered b; undetermined bits read 0
//   det_mask    out  WIDTH  1 = b bit uniquely determined
//   consistent  out  1      1 = some b exists with op(a,b) == r
//   err         out  1      illegal opcode
// BEHAVIOUR
//   - Reset: state IDLE; out_valid, b_out, det_mask, consistent, err = 0. in_ready = 1 in the first cycle after reset.
//   - FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
//   - IDLE, accept edge, legal op: register a, r, op. Clear b_out and det_mask, set consistent=1, err=0,
//     lane_idx=0, go to RUN.
//   - IDLE, accept edge, illegal op: go to DONE with err=1, b_out=0, det_mask=0, consistent=0.
//   - RUN: each edge processes lane lane_idx and writes its 4 b and 4 det bits.
//     consistent &= lane_ok. lane_idx++.
//     On the edge that processes lane NLANES-1, go to DONE.
//     out_valid is high NLANES edges after the accept edge (illegal op: 1 edge).
//   - DONE: all outputs held stable until the out_ready edge, then go to IDLE.
//     No same-cycle turnaround: the next accept is at the earliest one edge after the return to IDLE.
//   - in_valid outside IDLE is ignored. Inputs are sampled only on the accept edge.
//   - Per-bit inverse rules (ai, ri):
//       AND : ai=1 -> b=ri, det=1; ai=0 -> det=0, b=0, ok=~ri
//       OR  : ai=0 -> b=ri, det=1; ai=1 -> det=0, b=0, ok=ri
//       NAND/NOR: apply the AND/OR rule with ~ri
//       XOR : b=ai^ri, det=1, ok=1.  XNOR: b=~(ai^ri), det=1, ok=1
//   - b_out and det_mask are lane-local writes: never shifted, no carries.
//   - Reset during RUN or DONE: the transaction is abandoned; reset values apply on the next cycle.
// STRUCTURE
//   - bitwise_pkg: opcode localparams (OP_AND..OP_XNOR), FSM state encoding, LANE_W=4.
//   - Sub-module bitwise_lane_inv: combinational 4-bit lane.
//     Inputs a[3:0], r[3:0], op. Outputs b[3:0], det[3:0], ok (AND of 4 bit-oks).
//     Implemented with a task, as in the forward unit.
//   - Top: FSM, lane_idx counter ($clog2(NLANES) bits), lane mux/demux, result registers.
// TESTING (WIDTH=16)
//   1. XOR a=A5C3 r=FFFF -> b=5A3C det=FFFF consistent=1 err=0; out_valid exactly 4 edges after accept
//   2. AND a=00FF r=000F -> b=000F det=00FF consistent=1;
//      AND a=00F0 r=0100 -> b=0000 det=00F0 consistent=0
//   3. NOR a=F000 r=0F0F -> b=00F0 det=0FFF consistent=1
//   4. op=6 a=1234 r=5678 -> out_valid 1 edge after accept; err=1 b=0 det=0 consistent=0
//   5. out_ready low 3 cycles in DONE -> outputs stable, in_ready=0, in_valid pulse ignored;
//      out_ready high -> IDLE; next accept no earlier than 1 edge later
//   6. rst high for 1 edge after 2 RUN lanes -> next cycle out_valid=0, in_ready=1, all outputs 0;
//      the abandoned response never appears

Source files
------------

// File: rtl/bitwise_pkg.sv
// Shared definitions for the bitwise inverse decoder: opcodes, lane width and FSM encoding.
package bitwise_pkg;

    localparam int LANE_W = 4;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_XNOR);
    endfunction

endpackage

// File: rtl/bitwise_lane_inv.sv
// One 4-bit lane of the inverse: recovers b from a and r, flags determined bits and reachability.
module bitwise_lane_inv
    import bitwise_pkg::*;
(
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] r,
    input  logic [2:0]        op,
    output logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] det,
    output logic              ok
);

    // NAND/NOR reuse the AND/OR rules on the inverted result bit.
    task automatic inv_bit(
        input  logic       ai,
        input  logic       ri,
        input  logic [2:0] opc,
        output logic       bi,
        output logic       di,
        output logic       oki
    );
        logic rx;
        rx  = ri;
        bi  = 1'b0;
        di  = 1'b0;
        oki = 1'b0;
        case (opc)
            OP_AND, OP_NAND: begin
                rx = (opc == OP_NAND) ? ~ri : ri;
                if (ai) begin
                    bi  = rx;
                    di  = 1'b1;
                    oki = 1'b1;
                end else begin
                    oki = ~rx;
                end
            end
            OP_OR, OP_NOR: begin
                rx = (opc == OP_NOR) ? ~ri : ri;
                if (!ai) begin
                    bi  = rx;
                    di  = 1'b1;
                    oki = 1'b1;
                end else begin
                    oki = rx;
                end
            end
            OP_XOR: begin
                bi  = ai ^ ri;
                di  = 1'b1;
                oki = 1'b1;
            end
            OP_XNOR: begin
                bi  = ~(ai ^ ri);
                di  = 1'b1;
                oki = 1'b1;
            end
            default: ;
        endcase
    endtask

    logic bit_b;
    logic bit_det;
    logic bit_ok;

    always_comb begin
        b       = '0;
        det     = '0;
        ok      = 1'b1;
        bit_b   = 1'b0;
        bit_det = 1'b0;
        bit_ok  = 1'b0;
        for (int i = 0; i < LANE_W; i++) begin
            inv_bit(a[i], r[i], op, bit_b, bit_det, bit_ok);
            b[i]   = bit_b;
            det[i] = bit_det;
            ok     = ok & bit_ok;
        end
    end

endmodule

// File: rtl/bitwise_inverse_seq.sv
// Sequential inverse of the bitwise unit: walks the word one lane per clock, LSB lane first.
//   state   | meaning
//   IDLE    | ready for a request (in_ready=1)
//   RUN     | decoding lane lane_idx on each edge
//   DONE    | response held until out_ready
module bitwise_inverse_seq
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] r_in,
    input  logic [2:0]       op_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] det_mask,
    output logic             consistent,
    output logic             err
);

    // WIDTH is expected to be a whole number of lanes.
    localparam int NLANES = WIDTH / LANE_W;
    localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;

    state_t             state;
    logic [IDX_W-1:0]   lane_idx;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   r_reg;
    logic [2:0]         op_reg;

    logic [LANE_W-1:0]  lane_a;
    logic [LANE_W-1:0]  lane_r;
    logic [LANE_W-1:0]  lane_b;
    logic [LANE_W-1:0]  lane_det;
    logic               lane_ok;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    assign lane_a = a_reg[lane_idx*LANE_W +: LANE_W];
    assign lane_r = r_reg[lane_idx*LANE_W +: LANE_W];

    bitwise_lane_inv u_lane (
        .a   (lane_a),
        .r   (lane_r),
        .op  (op_reg),
        .b   (lane_b),
        .det (lane_det),
        .ok  (lane_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lane_idx   <= '0;
            a_reg      <= '0;
            r_reg      <= '0;
            op_reg     <= '0;
            b_out      <= '0;
            det_mask   <= '0;
            consistent <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        b_out    <= '0;
                        det_mask <= '0;
                        lane_idx <= '0;
                        if (op_is_legal(op_in)) begin
                            a_reg      <= a_in;
                            r_reg      <= r_in;
                            op_reg     <= op_in;
                            consistent <= 1'b1;
                            err        <= 1'b0;
                            state      <= ST_RUN;
                        end else begin
                            consistent <= 1'b0;
                            err        <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    b_out[lane_idx*LANE_W +: LANE_W]    <= lane_b;
                    det_mask[lane_idx*LANE_W +: LANE_W] <= lane_det;
                    consistent <= consistent & lane_ok;
                    lane_idx   <= lane_idx + 1'b1;
                    if (lane_idx == IDX_W'(NLANES - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_inverse_seq.sv
// Self-checking bench for bitwise_inverse_seq: directed cases plus random requests vs a word-level model.
module tb_bitwise_inverse_seq;

    localparam int W  = 16;
    localparam int NL = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] r_in = '0;
    logic [2:0]   op_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] b_out;
    logic [W-1:0] det_mask;
    logic         consistent;
    logic         err;

    int n_chk = 0;
    int n_bad = 0;

    bitwise_inverse_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .r_in       (r_in),
        .op_in      (op_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .b_out      (b_out),
        .det_mask   (det_mask),
        .consistent (consistent),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Whole-word inverse: AND-like ops fix b where a=1, OR-like ops where a=0.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] r, input logic [2:0] op,
                         output logic [W-1:0] b, output logic [W-1:0] det,
                         output logic cons, output logic e);
        logic [W-1:0] rr;
        rr = (op == 3'd2 || op == 3'd3) ? ~r : r;
        e  = 1'b0;
        case (op)
            3'd0, 3'd2: begin
                det  = a;
                b    = rr & a;
                cons = ((rr & ~a) == '0);
            end
            3'd1, 3'd3: begin
                det  = ~a;
                b    = rr & ~a;
                cons = ((~rr & a) == '0);
            end
            3'd4: begin
                det = '1; b = a ^ r; cons = 1'b1;
            end
            3'd5: begin
                det = '1; b = ~(a ^ r); cons = 1'b1;
            end
            default: begin
                det = '0; b = '0; cons = 1'b0; e = 1'b1;
            end
        endcase
    endtask

    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] r,
                           input logic [2:0] op, input int hold);
        logic [W-1:0] eb, ed;
        logic ec, ee;
        bit acc;
        int lat;
        model(a, r, op, eb, ed, ec, ee);
        a_in = a; r_in = r; op_in = op; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        a_in = W'($urandom); r_in = W'($urandom); op_in = 3'($urandom);
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        // Edges counted after the accept edge; an illegal op is already in DONE.
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", lat, ee ? 0 : NL);
        for (int h = 0; h <= hold; h++) begin
            chk("b_out", b_out, eb);
            chk("det_mask", det_mask, ed);
            chk("consistent", consistent, ec);
            chk("err", err, ee);
            chk("done_in_ready", in_ready, 0);
            chk("done_out_valid", out_valid, 1);
            in_valid = 1'b1;
            if (h == hold) out_ready = 1'b1;
            step();
        end
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_b_out", b_out, 0);
        chk("rst_det", det_mask, 0);
        chk("rst_consistent", consistent, 0);
        chk("rst_err", err, 0);

        run_txn(16'hA5C3, 16'hFFFF, 3'd4, 0);
        chk("xor_b_const", b_out, 16'h5A3C);
        run_txn(16'h00FF, 16'h000F, 3'd0, 0);
        run_txn(16'h00F0, 16'h0100, 3'd0, 0);
        run_txn(16'hF000, 16'h0F0F, 3'd3, 0);
        chk("nor_det_const", det_mask, 16'h0FFF);
        run_txn(16'h1234, 16'h5678, 3'd6, 0);
        run_txn(16'hBEEF, 16'h1357, 3'd5, 3);
        run_txn(16'h0F0F, 16'hF0F0, 3'd2, 2);
        run_txn(16'h3C3C, 16'h3CFF, 3'd1, 1);
        run_txn(16'h0000, 16'h0000, 3'd7, 2);

        for (int k = 0; k < 30; k++)
            run_txn(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 3));

        // Abandon a transaction after two lanes.
        a_in = 16'hFFFF; r_in = 16'hFFFF; op_in = 3'd4; in_valid = 1'b1;
        chk("abort_pre_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_b_out", b_out, 0);
        chk("abort_det", det_mask, 0);
        chk("abort_consistent", consistent, 0);
        chk("abort_err", err, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("abort_no_resp", out_valid, 0);
        end
        run_txn(16'h1111, 16'h2222, 3'd4, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
